// File: rtl/jt12_eg_pkg.sv
// Shared constants for the per-slot envelope generator: phase codes,
// attenuation limit, slot count and bit layout of the packed state word.
package jt12_eg_pkg;

  // ADSR phase codes carried in the packed state word
  localparam logic [1:0] ATTACK  = 2'd0;
  localparam logic [1:0] DECAY   = 2'd1;
  localparam logic [1:0] SUSTAIN = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [9:0] EG_MAX = 10'h3FF;  // full attenuation (silence)
  localparam int SLOTS = 24;
  localparam int ST_W  = 13;

  // Packed state word: [12]=keyon_prev, [11:10]=phase, [9:0]=attenuation
  localparam int KON_BIT = 12;
  localparam int PH_HI   = 11;
  localparam int PH_LO   = 10;
  localparam int EG_HI   = 9;
  localparam int EG_LO   = 0;

endpackage

// File: rtl/jt12_eg_inc.sv
// Rate table: turns the active rate, the global envelope counter and the
// per-round tick into an update strobe and an attenuation step size.
module jt12_eg_inc #(
  parameter int CNT_W = 12
) (
  input  logic [5:0]       rate,
  input  logic [CNT_W-1:0] eg_cnt,
  input  logic             eg_tick,
  output logic             upd,
  output logic [3:0]       step
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [3:0]       rate_hi;
  logic [3:0]       sh;
  logic [CNT_W-1:0] mask;

  // Slow rates update on counter multiples of 2^sh; fast rates every tick with a larger step
  always_comb begin
    rate_hi = rate[5:2];
    sh      = (rate_hi >= 4'd11) ? 4'd0 : 4'd11 - rate_hi;
    mask    = (ONE << sh) - ONE;
    step    = 4'd1;
    upd     = 1'b0;
    if (rate >= 6'd48) begin
      // rate_hi 12..15 -> step 1, 2, 4, 8
      step = 4'd1 << (rate_hi - 4'd12);
      upd  = eg_tick;
    end else if (rate != 6'd0) begin
      upd = eg_tick && ((eg_cnt & mask) == '0);
    end
  end

endmodule

// File: rtl/jt12_eg_slot.sv
// Per-slot envelope state update. Reads one slot's packed state from the
// external 24-deep ring, computes the next ADSR phase and attenuation and
// registers it back out; also owns the slot counter and envelope tick counter.
module jt12_eg_slot #(
  parameter int SLOTS  = 24,
  parameter int EG_DIV = 3,
  parameter int CNT_W  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [jt12_eg_pkg::ST_W-1:0] st_in,
  input  logic                         keyon,
  input  logic [5:0]                   ar,
  input  logic [5:0]                   d1r,
  input  logic [5:0]                   d2r,
  input  logic [5:0]                   rr,
  input  logic [3:0]                   sl,
  output logic [jt12_eg_pkg::ST_W-1:0] st_out,
  output logic [9:0]                   eg_out,
  output logic [4:0]                   slot,
  output logic                         zero,
  output logic [CNT_W-1:0]             eg_cnt
);

  import jt12_eg_pkg::*;

  localparam int DIV_W = (EG_DIV > 1) ? $clog2(EG_DIV) : 1;

  logic [4:0]       slot_reg;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;
  logic [ST_W-1:0]  st_reg;

  logic [4:0]      slot_next;
  logic            wrap;
  logic            tick_now;
  logic            kon_prev;
  logic [1:0]      phase;
  logic [9:0]      eg;
  logic [5:0]      rate;
  logic            upd;
  logic [3:0]      step;
  logic [13:0]     prod;
  logic [10:0]     dec;
  logic [10:0]     sum;
  logic [9:0]      att_eg;
  logic [9:0]      inc_eg;
  logic [9:0]      sus_lvl;
  logic [1:0]      ph_next;
  logic [9:0]      eg_next;
  logic [ST_W-1:0] st_next;

  // Slot sequencing; the tick decided when slot_reg is 0 stays valid for the rest of the round
  always_comb begin
    wrap      = (slot_reg == 5'(SLOTS - 1));
    slot_next = wrap ? 5'd0 : slot_reg + 5'd1;
    tick_now  = (slot_reg == 5'd0) ? (div_reg == DIV_W'(EG_DIV - 1)) : tick_reg;
  end

  // Unpack the incoming word and select the rate of the current phase
  always_comb begin
    kon_prev = st_in[KON_BIT];
    phase    = st_in[PH_HI:PH_LO];
    eg       = st_in[EG_HI:EG_LO];
    case (phase)
      ATTACK:  rate = ar;
      DECAY:   rate = d1r;
      SUSTAIN: rate = d2r;
      default: rate = rr;
    endcase
  end

  jt12_eg_inc #(
    .CNT_W (CNT_W)
  ) u_inc (
    .rate    (rate),
    .eg_cnt  (cnt_reg),
    .eg_tick (tick_now),
    .upd     (upd),
    .step    (step)
  );

  // Candidate attenuations: exponential attack toward 0, linear climb capped at EG_MAX
  always_comb begin
    prod    = 14'(eg) * 14'(step);
    dec     = {1'b0, prod[13:4]} + 11'd1;
    att_eg  = ({1'b0, eg} > dec) ? (eg - dec[9:0]) : 10'd0;
    sum     = {1'b0, eg} + {7'd0, step};
    inc_eg  = (sum > {1'b0, EG_MAX}) ? EG_MAX : sum[9:0];
    sus_lvl = (sl == 4'hF) ? 10'h3E0 : {1'b0, sl, 5'd0};
  end

  // Phase transitions: key edges win over rate-driven updates
  always_comb begin
    ph_next = phase;
    eg_next = eg;
    if (keyon && !kon_prev) begin
      if (ar >= 6'd62) begin
        ph_next = DECAY;
        eg_next = 10'd0;
      end else begin
        ph_next = ATTACK;
      end
    end else if (!keyon && kon_prev) begin
      ph_next = RELEASE;
    end else if (phase == ATTACK) begin
      if (upd) eg_next = att_eg;
      // An attack already at 0 moves on without waiting for an update
      if (eg_next == 10'd0) ph_next = DECAY;
    end else begin
      if (upd) eg_next = inc_eg;
      if (phase == DECAY && eg_next >= sus_lvl) ph_next = SUSTAIN;
    end
    st_next = {keyon, ph_next, eg_next};
  end

  // Slot counter, round divider and global envelope counter
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= 5'd0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (clk_en) begin
      slot_reg <= slot_next;
      tick_reg <= tick_now;
      if (wrap) begin
        if (div_reg == DIV_W'(EG_DIV - 1)) begin
          div_reg <= '0;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else begin
          div_reg <= div_reg + DIV_W'(1);
        end
      end
    end
  end

  // Output state word; reset value matches the ring's all-ones attenuation in RELEASE
  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg <= {1'b0, RELEASE, EG_MAX};
    end else if (clk_en) begin
      st_reg <= st_next;
    end
  end

  assign st_out = st_reg;
  assign eg_out = st_reg[EG_HI:EG_LO];
  assign slot   = slot_reg;
  assign zero   = (slot_reg == 5'd0);
  assign eg_cnt = cnt_reg;

endmodule

// File: tb/tb_jt12_eg_slot.sv
// Directed bench for jt12_eg_slot: closes the 24-cycle state loop through a
// behavioural 23-stage ring and walks each slot through its ADSR phases.
module tb_jt12_eg_slot;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [12:0] st_in;
  logic        keyon;
  logic [5:0]  ar, d1r, d2r, rr;
  logic [3:0]  sl;
  logic [12:0] st_out;
  logic [9:0]  eg_out;
  logic [4:0]  slot;
  logic        zero;
  logic [11:0] eg_cnt;

  always #5 clk = ~clk;

  jt12_eg_slot #(
    .SLOTS  (24),
    .EG_DIV (3),
    .CNT_W  (12)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .st_in  (st_in),
    .keyon  (keyon),
    .ar     (ar),
    .d1r    (d1r),
    .d2r    (d2r),
    .rr     (rr),
    .sl     (sl),
    .st_out (st_out),
    .eg_out (eg_out),
    .slot   (slot),
    .zero   (zero),
    .eg_cnt (eg_cnt)
  );

  // 23-stage state ring, reset to all ones
  logic [12:0] ring [0:22];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 23; i++) ring[i] <= 13'h1FFF;
    end else if (clk_en) begin
      ring[0] <= st_out;
      for (int i = 1; i < 23; i++) ring[i] <= ring[i-1];
    end
  end
  assign st_in = ring[22];

  // Per-slot stimulus
  logic       kon_a [24];
  logic [5:0] ar_a  [24];
  logic [5:0] d1r_a [24];
  logic [5:0] d2r_a [24];
  logic [5:0] rr_a  [24];
  logic [3:0] sl_a  [24];

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;   // clk_en edges since reset
  int exp_slot = 0;

  // One clk_en edge; inputs belong to the slot that the next word will carry
  task automatic cyc();
    int p;
    p = (exp_slot == 23) ? 0 : exp_slot + 1;
    keyon = kon_a[p]; ar = ar_a[p]; d1r = d1r_a[p];
    d2r = d2r_a[p]; rr = rr_a[p]; sl = sl_a[p];
    clk_en = 1'b1;
    @(posedge clk); #1;
    exp_slot = p;
    ncyc++;
  endtask

  // Words produced in edges 49..72 of every 72 belong to a tick round
  function automatic bit is_tick(input int n);
    return (n > 0) && ((n % 72 == 0) || (n % 72 >= 49));
  endfunction

  task automatic run_to_slot(input int s);
    int k;
    k = 0;
    do begin cyc(); k++; end while (exp_slot != s && k < 24);
  endtask

  task automatic run_to_tick(input int s);
    int k;
    k = 0;
    do begin cyc(); k++; end while (!(exp_slot == s && is_tick(ncyc)) && k < 100);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 24; i++) begin
      kon_a[i] = 1'b0; ar_a[i] = 6'd0; d1r_a[i] = 6'd0;
      d2r_a[i] = 6'd0; rr_a[i] = 6'd0; sl_a[i] = 4'd15;
    end
    rst = 1'b1; clk_en = 1'b0; keyon = 1'b0;
    ar = 6'd0; d1r = 6'd0; d2r = 6'd0; rr = 6'd0; sl = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    total++; if (st_out !== 13'h0FFF) begin bad++; $display("FAIL reset_st got=%h want=0fff", st_out); end
    total++; if (slot !== 5'd0) begin bad++; $display("FAIL reset_slot got=%0d want=0", slot); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    total++; if (eg_cnt !== 12'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", eg_cnt); end
    rst = 1'b0; ncyc = 0; exp_slot = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 72; i++) begin
      cyc();
      total++; if (st_out !== 13'h0FFF) begin bad++; $display("FAIL idle_st n=%0d got=%h want=0fff", ncyc, st_out); end
      total++; if (slot !== 5'(exp_slot)) begin bad++; $display("FAIL idle_slot n=%0d got=%0d want=%0d", ncyc, slot, exp_slot); end
      total++; if (zero !== (exp_slot == 0)) begin bad++; $display("FAIL idle_zero n=%0d got=%b want=%b", ncyc, zero, exp_slot == 0); end
      total++; if (eg_cnt !== 12'(ncyc / 72)) begin bad++; $display("FAIL idle_cnt n=%0d got=%0d want=%0d", ncyc, eg_cnt, ncyc / 72); end
    end
    total++; if (eg_cnt !== 12'd1) begin bad++; $display("FAIL idle_cnt72 got=%0d want=1", eg_cnt); end
  endtask

  task automatic test_instant_attack();
    logic [12:0] want;
    kon_a[5] = 1'b1; ar_a[5] = 6'd63;
    for (int i = 0; i < 48; i++) begin
      cyc();
      want = (exp_slot == 5) ? 13'h1400 : 13'h0FFF;
      total++; if (st_out !== want) begin bad++; $display("FAIL instant slot=%0d got=%h want=%h", exp_slot, st_out, want); end
    end
  endtask

  task automatic test_attack_slow();
    logic [9:0]  upd_tab [2];
    logic [9:0]  prev, e;
    logic [12:0] want;
    int nupd;
    upd_tab[0] = 10'h3BF; upd_tab[1] = 10'h383;
    kon_a[0] = 1'b1; ar_a[0] = 6'd20; d1r_a[0] = 6'd0;
    run_to_slot(0);
    total++; if (st_out !== 13'h13FF) begin bad++; $display("FAIL slow_keyon got=%h want=13ff", st_out); end
    prev = 10'h3FF; nupd = 0;
    for (int it = 0; it < 450 && nupd < 2; it++) begin
      run_to_slot(0);
      if (is_tick(ncyc) && (((ncyc - 1) / 72) % 64 == 0)) begin
        e = upd_tab[nupd]; nupd++;
      end else begin
        e = prev;
      end
      want = {1'b1, 2'b00, e};
      total++; if (st_out !== want) begin bad++; $display("FAIL slow_attack n=%0d got=%h want=%h", ncyc, st_out, want); end
      prev = e;
    end
  endtask

  task automatic test_attack_fast();
    logic [9:0]  att_tab [9];
    logic [12:0] want;
    att_tab[0] = 10'd511; att_tab[1] = 10'd255; att_tab[2] = 10'd127;
    att_tab[3] = 10'd63;  att_tab[4] = 10'd31;  att_tab[5] = 10'd15;
    att_tab[6] = 10'd7;   att_tab[7] = 10'd3;   att_tab[8] = 10'd1;
    kon_a[7] = 1'b1; ar_a[7] = 6'd60; d1r_a[7] = 6'd60;
    d2r_a[7] = 6'd0; rr_a[7] = 6'd63; sl_a[7] = 4'd2;
    run_to_slot(7);
    total++; if (st_out !== 13'h13FF) begin bad++; $display("FAIL fast_keyon got=%h want=13ff", st_out); end
    for (int i = 0; i < 9; i++) begin
      run_to_tick(7);
      want = {1'b1, 2'b00, att_tab[i]};
      total++; if (st_out !== want) begin bad++; $display("FAIL fast_attack i=%0d got=%h want=%h", i, st_out, want); end
    end
    run_to_tick(7);
    total++; if (st_out !== 13'h1400) begin bad++; $display("FAIL attack_to_decay got=%h want=1400", st_out); end
  endtask

  task automatic test_decay();
    logic [12:0] want;
    for (int v = 8; v < 64; v += 8) begin
      run_to_tick(7);
      want = {1'b1, 2'b01, 10'(v)};
      total++; if (st_out !== want) begin bad++; $display("FAIL decay v=%0d got=%h want=%h", v, st_out, want); end
    end
    run_to_tick(7);
    total++; if (st_out !== 13'h1840) begin bad++; $display("FAIL sustain_entry got=%h want=1840", st_out); end
    run_to_tick(7);
    total++; if (st_out !== 13'h1840) begin bad++; $display("FAIL sustain_hold got=%h want=1840", st_out); end
  endtask

  task automatic test_release();
    int e;
    logic [12:0] want;
    kon_a[7] = 1'b0;
    run_to_slot(7);
    total++; if (st_out !== 13'h0C40) begin bad++; $display("FAIL release_entry got=%h want=0c40", st_out); end
    e = 64;
    for (int i = 0; i < 121; i++) begin
      e = (e + 8 > 1023) ? 1023 : e + 8;
      run_to_tick(7);
      want = {1'b0, 2'b11, 10'(e)};
      total++; if (st_out !== want) begin bad++; $display("FAIL release i=%0d got=%h want=%h", i, st_out, want); end
    end
  endtask

  task automatic test_hold_reset();
    int cnt_now;
    kon_a[9] = 1'b1; ar_a[9] = 6'd20;
    run_to_slot(9);
    total++; if (st_out !== 13'h13FF) begin bad++; $display("FAIL hold_keyon got=%h want=13ff", st_out); end
    cnt_now = ncyc / 72;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (st_out !== 13'h13FF) begin bad++; $display("FAIL hold_st got=%h want=13ff", st_out); end
    total++; if (slot !== 5'd9) begin bad++; $display("FAIL hold_slot got=%0d want=9", slot); end
    total++; if (eg_cnt !== 12'(cnt_now)) begin bad++; $display("FAIL hold_cnt got=%0d want=%0d", eg_cnt, cnt_now); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (st_out !== 13'h0FFF) begin bad++; $display("FAIL midrst_st got=%h want=0fff", st_out); end
    total++; if (slot !== 5'd0) begin bad++; $display("FAIL midrst_slot got=%0d want=0", slot); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL midrst_zero got=%b want=1", zero); end
    total++; if (eg_cnt !== 12'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", eg_cnt); end
    rst = 1'b0; ncyc = 0; exp_slot = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) kon_a[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      total++; if (st_out !== 13'h0FFF) begin bad++; $display("FAIL b2b_st slot=%0d got=%h want=0fff", exp_slot, st_out); end
      total++; if (zero !== (exp_slot == 0)) begin bad++; $display("FAIL b2b_zero slot=%0d got=%b", exp_slot, zero); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_instant_attack();
    test_attack_slow();
    test_attack_fast();
    test_decay();
    test_release();
    test_hold_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
